// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronizes and deglitches SCL/SDA, flags START/STOP,
// and derives busy, free and stretched-activity status for the power manager.

module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic pad,
  output logic filt
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             stable_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // The filtered value only follows the synced value once it has disagreed
  // for FILTER_LEN consecutive cycles; any agreement restarts the count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else if (synced == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FILT_LAST) begin
      filt       <= synced;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

endmodule

module i2c_bus_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int BUS_FREE_CYCLES = 64
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_filt,
  output logic o_sda_filt,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_bus_busy,
  output logic o_bus_free,
  output logic o_bus_activity
);

  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES);
  localparam logic [15:0] FREE_LIMIT = 16'(BUS_FREE_CYCLES);

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_t;

  bus_state_t  state_q, state_d;
  logic        scl_prev, sda_prev;
  logic        scl_high_both, start_cond, stop_cond, line_edge;
  logic [15:0] hold_q, hold_d;
  logic [15:0] free_q, free_d;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .sys_clk (i_sys_clk),
    .rst_n   (i_rst_n),
    .pad     (i_scl),
    .filt    (o_scl_filt)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .sys_clk (i_sys_clk),
    .rst_n   (i_rst_n),
    .pad     (i_sda),
    .filt    (o_sda_filt)
  );

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= o_scl_filt;
      sda_prev <= o_sda_filt;
    end
  end

  // A simultaneous SCL/SDA change fails the "SCL high in both cycles" test,
  // so it is never mistaken for START/STOP but still counts as an edge.
  assign scl_high_both = o_scl_filt & scl_prev;
  assign start_cond    = scl_high_both &  sda_prev & ~o_sda_filt;
  assign stop_cond     = scl_high_both & ~sda_prev &  o_sda_filt;
  assign line_edge     = (o_scl_filt ^ scl_prev) | (o_sda_filt ^ sda_prev);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = BUS_IDLE;
    end else if (start_cond) begin
      state_d = BUS_BUSY;
    end else if (stop_cond) begin
      state_d = BUS_IDLE;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (!i_enable) begin
      hold_d = '0;
    end else if (line_edge) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 16'd0) begin
      hold_d = hold_q - 16'd1;
    end
  end

  // Bus-free qualifies on the registered busy state so a fresh START drops
  // o_bus_free in the same cycle the START pulse appears.
  always_comb begin
    free_d = '0;
    if (i_enable && (state_q == BUS_IDLE) && o_scl_filt && o_sda_filt) begin
      free_d = (free_q == FREE_LIMIT) ? FREE_LIMIT : free_q + 16'd1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q         <= '0;
      free_q         <= '0;
      o_start_det    <= 1'b0;
      o_stop_det     <= 1'b0;
      o_bus_free     <= 1'b0;
      o_bus_activity <= 1'b0;
    end else begin
      hold_q         <= hold_d;
      free_q         <= free_d;
      o_start_det    <= i_enable & start_cond;
      o_stop_det     <= i_enable & stop_cond;
      o_bus_free     <= (free_d == FREE_LIMIT);
      o_bus_activity <= (state_d == BUS_BUSY) | (hold_d != 16'd0);
    end
  end

  assign o_bus_busy = (state_q == BUS_BUSY);

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed self-checking bench for i2c_bus_monitor at default parameters.

module tb_i2c_bus_monitor;

  logic sysClk = 1'b0;
  logic rstN;
  logic enable;
  logic scl;
  logic sda;
  logic sclFilt, sdaFilt, startDet, stopDet, busBusy, busFree, busActivity;

  int checks     = 0;
  int failures   = 0;
  int startCount = 0;
  int stopCount  = 0;
  int startBase, stopBase;

  i2c_bus_monitor dut (
    .i_sys_clk      (sysClk),
    .i_rst_n        (rstN),
    .i_enable       (enable),
    .i_scl          (scl),
    .i_sda          (sda),
    .o_scl_filt     (sclFilt),
    .o_sda_filt     (sdaFilt),
    .o_start_det    (startDet),
    .o_stop_det     (stopDet),
    .o_bus_busy     (busBusy),
    .o_bus_free     (busFree),
    .o_bus_activity (busActivity)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    if (startDet) startCount++;
    if (stopDet)  stopCount++;
  end

  task automatic applyStimulus(input logic sclVal, input logic sdaVal);
    scl = sclVal;
    sda = sdaVal;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    rstN   = 1'b0;
    enable = 1'b1;
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(posedge sysClk);
    #1;
    checkOutput("rst_scl_filt", sclFilt, 1);
    checkOutput("rst_sda_filt", sdaFilt, 1);
    checkOutput("rst_start", startDet, 0);
    checkOutput("rst_stop", stopDet, 0);
    checkOutput("rst_busy", busBusy, 0);
    checkOutput("rst_free", busFree, 0);
    checkOutput("rst_activity", busActivity, 0);

    // Bus-free rises exactly 64 edges after reset release.
    rstN = 1'b1;
    waitCycles(63);
    checkOutput("free_at_63", busFree, 0);
    checkOutput("idle_activity", busActivity, 0);
    checkOutput("idle_busy", busBusy, 0);
    waitCycles(1);
    checkOutput("free_at_64", busFree, 1);

    // Two-cycle SDA glitch must be swallowed by the filter.
    startBase = startCount;
    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      waitCycles(1);
      checkOutput("glitch_sda_filt", sdaFilt, 1);
      checkOutput("glitch_activity", busActivity, 0);
    end
    checkOutput("glitch_no_start", startCount - startBase, 0);
    checkOutput("glitch_free", busFree, 1);

    // START, SCL low, SCL high, STOP.
    applyStimulus(1'b1, 1'b0);
    waitCycles(5);
    checkOutput("start_sda_filt_e5", sdaFilt, 0);
    checkOutput("start_pulse_e5", startDet, 0);
    waitCycles(1);
    checkOutput("start_pulse_e6", startDet, 1);
    checkOutput("start_busy_e6", busBusy, 1);
    checkOutput("start_activity_e6", busActivity, 1);
    checkOutput("start_free_e6", busFree, 0);
    waitCycles(1);
    checkOutput("start_pulse_e7", startDet, 0);
    applyStimulus(1'b0, 1'b0);
    waitCycles(10);
    checkOutput("scl_low_filt", sclFilt, 0);
    checkOutput("scl_low_busy", busBusy, 1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(10);
    checkOutput("scl_rise_no_stop", stopCount, 0);
    applyStimulus(1'b1, 1'b1);
    waitCycles(5);
    checkOutput("stop_pulse_e5", stopDet, 0);
    waitCycles(1);
    checkOutput("stop_pulse_e6", stopDet, 1);
    checkOutput("stop_busy", busBusy, 0);
    checkOutput("stop_activity", busActivity, 1);
    waitCycles(15);
    checkOutput("hold_last_cycle", busActivity, 1);
    waitCycles(1);
    checkOutput("hold_expired", busActivity, 0);
    waitCycles(47);
    checkOutput("refree_63", busFree, 0);
    waitCycles(1);
    checkOutput("refree_64", busFree, 1);

    // START, data toggles, repeated START, STOP.
    startBase = startCount;
    stopBase  = stopCount;
    applyStimulus(1'b1, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    checkOutput("rs_busy_data", busBusy, 1);
    applyStimulus(1'b1, 1'b1);
    waitCycles(8);
    applyStimulus(1'b1, 1'b0);
    waitCycles(6);
    checkOutput("rs_pulse", startDet, 1);
    checkOutput("rs_busy", busBusy, 1);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(8);
    applyStimulus(1'b1, 1'b0);
    waitCycles(8);
    checkOutput("rs_busy_before_stop", busBusy, 1);
    applyStimulus(1'b1, 1'b1);
    waitCycles(8);
    checkOutput("rs_busy_after_stop", busBusy, 0);
    checkOutput("rs_start_count", startCount - startBase, 2);
    checkOutput("rs_stop_count", stopCount - stopBase, 1);
    waitCycles(20);

    // SCL and SDA move together: activity only, no START/STOP.
    startBase = startCount;
    stopBase  = stopCount;
    applyStimulus(1'b0, 1'b0);
    waitCycles(5);
    checkOutput("same_activity_e5", busActivity, 0);
    waitCycles(1);
    checkOutput("same_activity_e6", busActivity, 1);
    checkOutput("same_busy", busBusy, 0);
    waitCycles(15);
    checkOutput("same_hold_last", busActivity, 1);
    waitCycles(1);
    checkOutput("same_hold_expired", busActivity, 0);
    applyStimulus(1'b1, 1'b1);
    waitCycles(10);
    checkOutput("same_no_start", startCount - startBase, 0);
    checkOutput("same_no_stop", stopCount - stopBase, 0);
    waitCycles(20);

    // Disable mid-transaction, toggle pads, re-enable and STOP.
    applyStimulus(1'b1, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0);
    waitCycles(8);
    checkOutput("en_busy_before", busBusy, 1);
    checkOutput("en_activity_before", busActivity, 1);
    startBase = startCount;
    stopBase  = stopCount;
    enable = 1'b0;
    waitCycles(1);
    checkOutput("dis_busy", busBusy, 0);
    checkOutput("dis_activity", busActivity, 0);
    checkOutput("dis_free", busFree, 0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1);
    waitCycles(8);
    applyStimulus(1'b1, 1'b0);
    waitCycles(8);
    checkOutput("dis_no_start", startCount - startBase, 0);
    checkOutput("dis_sda_track", sdaFilt, 0);
    checkOutput("dis_scl_track", sclFilt, 1);
    checkOutput("dis_activity_late", busActivity, 0);
    enable = 1'b1;
    waitCycles(3);
    checkOutput("reen_busy", busBusy, 0);
    checkOutput("reen_activity", busActivity, 0);
    applyStimulus(1'b1, 1'b1);
    waitCycles(6);
    checkOutput("reen_stop_pulse", stopDet, 1);
    checkOutput("reen_stop_busy", busBusy, 0);
    waitCycles(1);
    checkOutput("reen_stop_count", stopCount - stopBase, 1);
    waitCycles(20);

    // Async reset in the middle of a transaction.
    applyStimulus(1'b1, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0);
    waitCycles(8);
    checkOutput("ar_busy_before", busBusy, 1);
    checkOutput("ar_sda_before", sdaFilt, 0);
    startBase = startCount;
    stopBase  = stopCount;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("ar_busy", busBusy, 0);
    checkOutput("ar_activity", busActivity, 0);
    checkOutput("ar_free", busFree, 0);
    checkOutput("ar_scl_filt", sclFilt, 1);
    checkOutput("ar_sda_filt", sdaFilt, 1);
    applyStimulus(1'b1, 1'b1);
    waitCycles(3);
    rstN = 1'b1;
    waitCycles(20);
    checkOutput("ar_no_stop", stopCount - stopBase, 0);
    checkOutput("ar_no_start", startCount - startBase, 0);
    checkOutput("ar_busy_after", busBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
